draw_rect_ctl: RTL
==================

DRAW_RECT_CTL -- requirements
Module: draw_rect_ctl

Interface
REQ-001 Parameter RECT_HEIGHT, default 64: rectangle/image height in pixels.
REQ-002 Parameter SCREEN_HEIGHT, default 600: visible lines.
REQ-003 Parameter ACCEL, default 1: speed increment per frame while falling.
REQ-004 Parameter MAX_SPEED, default 32: speed ceiling in pixels/frame, at most 63.
REQ-005 pclk  input  1  pixel clock; the only clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 mouse_xpos  input  12  mouse X position, unsigned.
REQ-008 mouse_ypos  input  12  mouse Y position, unsigned.
REQ-009 mouse_left  input  1  left button level, already synchronous to pclk.
REQ-010 vsync_in  input  1  vertical sync from the timing pipeline; its rising edge marks a frame boundary.
REQ-011 xpos  output  12  registered rectangle X for the draw pipeline.
REQ-012 ypos  output  12  registered rectangle Y for the draw pipeline.
REQ-013 falling  output  1  registered; high while in FALL.

Function
REQ-014 BOTTOM SHALL equal SCREEN_HEIGHT-RECT_HEIGHT (536 at defaults), computed at elaboration.
REQ-015 A one-cycle frame tick SHALL be asserted in the cycle after vsync_in is sampled 0 and then 1.
REQ-016 xpos, ypos, falling and the state SHALL change only on the pclk edge where tick=1. They SHALL hold for the rest of the frame.
REQ-017 mouse_left SHALL be sampled only at ticks. click = sample AND NOT previous-tick sample.
REQ-018 The FSM SHALL have three states: IDLE, FALL and LANDED.
REQ-019 IDLE on tick SHALL do the following:
- xpos <= mouse_xpos.
- ypos <= min(mouse_ypos, BOTTOM).
- If click, go to FALL and set speed <= 0, using the mouse values sampled at that tick.
REQ-020 FALL on tick SHALL do the following:
- Compute next = ypos + speed in 13 bits, so there is no wrap.
- If next >= BOTTOM, set ypos <= BOTTOM and go to LANDED.
- Otherwise set ypos <= next.
- speed <= min(speed+ACCEL, MAX_SPEED) in all cases.
REQ-021 In FALL and LANDED, xpos SHALL be frozen and mouse position SHALL be ignored.
REQ-022 LANDED on tick SHALL hold ypos=BOTTOM and go to IDLE on click. That same tick does not update xpos/ypos; IDLE updates start at the next tick.
REQ-023 A click in FALL SHALL be ignored; the edge detector still updates.
REQ-024 speed SHALL be 6 bits. The saturation compare SHALL be done before the add so that it cannot overflow.
REQ-025 falling SHALL be 1 exactly while the state is FALL, registered together with the state.
REQ-026 Without ticks (vsync_in static), all outputs SHALL hold indefinitely.
REQ-027 Latency SHALL be exactly 1 pclk from the tick cycle to the updated outputs.

Reset
REQ-028 When rst=1 at a pclk edge, the following SHALL be set, overriding any tick in the same cycle:
- state=IDLE, xpos=0, ypos=0, falling=0, speed=0.
- Button history=0, vsync history=1 (no spurious tick right after reset).
REQ-029 Reset mid-FALL SHALL abandon the fall. The first tick after release follows the IDLE rules.

Verification
REQ-030 IDLE follow: mouse_xpos=100, mouse_ypos=200, with 2 vsync rising edges -> xpos=100, ypos=200 one pclk after each tick; the outputs are unchanged between ticks.
REQ-031 Clamp: mouse_ypos=700 in IDLE -> ypos=536 after the tick.
REQ-032 Fall/land: ypos=530, mouse_left rises before a tick, then frames continue. The sequence is:
- falling=1, ypos=530.
- Then ypos=530, 531, 533.
- Then 536 with falling=0 (LANDED). xpos stays constant throughout.
REQ-033 Saturation: fall from ypos=0 with MAX_SPEED=4 -> per-frame ypos deltas of 0, 1, 2, 3, 4, 4, 4..., ending exactly at 536.
REQ-034 Held button: mouse_left held at 1 across LANDED -> stays LANDED. Release, then press -> IDLE, and ypos follows the mouse from the next tick.
REQ-035 Reset: assert rst mid-FALL coincident with a tick -> xpos=0, ypos=0, falling=0 next cycle. vsync_in held high through the release -> no tick until the next 0->1 transition.

Source files
------------

// File: rtl/draw_rect_ctl.sv
// Falling-rectangle position controller: follows the mouse in IDLE, drops under
// constant acceleration after a click, rests at the bottom until the next click.
module draw_rect_ctl #(
  parameter int RECT_HEIGHT   = 64,
  parameter int SCREEN_HEIGHT = 600,
  parameter int ACCEL         = 1,
  parameter int MAX_SPEED     = 32
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  input  logic        vsync_in,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        falling,
  output logic [1:0]  state_dbg
);

  localparam logic [11:0] BOTTOM  = 12'(SCREEN_HEIGHT - RECT_HEIGHT);
  localparam logic [5:0]  MAX_SPD = 6'(MAX_SPEED);
  localparam logic [5:0]  ACC     = 6'(ACCEL);
  // Speeds at or above this threshold would reach/overshoot the ceiling after
  // one more increment, so the add is never performed for them.
  localparam logic [5:0]  SAT_TH  = 6'((ACCEL >= MAX_SPEED) ? 0 : MAX_SPEED - ACCEL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FALL   = 2'd1,
    LANDED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        vsync_prev;
  logic        tick;
  logic        btn_prev, btn_nxt;
  logic [5:0]  speed, speed_nxt;
  logic [11:0] xpos_nxt, ypos_nxt;
  logic        click;
  logic [12:0] y_sum;
  logic [11:0] mouse_y_clamped;

  assign state_dbg = state;

  always_comb begin
    state_nxt       = state;
    xpos_nxt        = xpos;
    ypos_nxt        = ypos;
    speed_nxt       = speed;
    btn_nxt         = btn_prev;
    click           = mouse_left & ~btn_prev;
    y_sum           = {1'b0, ypos} + {7'b0, speed};
    mouse_y_clamped = (mouse_ypos > BOTTOM) ? BOTTOM : mouse_ypos;
    if (tick) begin
      btn_nxt = mouse_left;
      case (state)
        IDLE: begin
          xpos_nxt = mouse_xpos;
          ypos_nxt = mouse_y_clamped;
          if (click) begin
            state_nxt = FALL;
            speed_nxt = 6'd0;
          end
        end
        FALL: begin
          if (y_sum >= {1'b0, BOTTOM}) begin
            ypos_nxt  = BOTTOM;
            state_nxt = LANDED;
          end else begin
            ypos_nxt = y_sum[11:0];
          end
          speed_nxt = (speed >= SAT_TH) ? MAX_SPD : speed + ACC;
        end
        LANDED: begin
          ypos_nxt = BOTTOM;
          if (click) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= IDLE;
      xpos       <= 12'd0;
      ypos       <= 12'd0;
      falling    <= 1'b0;
      speed      <= 6'd0;
      btn_prev   <= 1'b0;
      vsync_prev <= 1'b1;
      tick       <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      tick       <= vsync_in & ~vsync_prev;
      state      <= state_nxt;
      xpos       <= xpos_nxt;
      ypos       <= ypos_nxt;
      falling    <= (state_nxt == FALL);
      speed      <= speed_nxt;
      btn_prev   <= btn_nxt;
    end
  end

endmodule
